// File: rtl/bus_bridge_pkg.sv
// Shared constants for bus_bridge: peripheral page, register offsets and the
// BRIDGE_TIMER_EN build switch (TIMER_EN mirrors it for use in expressions).
package bus_bridge_pkg;

  localparam logic [19:0] PERIPH_PAGE = 20'hFFFFF;

  localparam logic [11:0] OFF_SEG   = 12'h000;
  localparam logic [11:0] OFF_TCNT  = 12'h020;
  localparam logic [11:0] OFF_TCMP  = 12'h024;
  localparam logic [11:0] OFF_TSTAT = 12'h028;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;
  localparam logic [11:0] OFF_BTN   = 12'h078;

`ifdef BRIDGE_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

endpackage

// File: rtl/bus_bridge_timer.sv
// bridge_timer: prescaled 32-bit up-counter with compare match and a sticky
// RW1C status flag. Only instantiated when BRIDGE_TIMER_EN is defined.
module bridge_timer #(
  parameter int TIMER_DIV = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tcnt_we,
  input  logic        tcmp_we,
  input  logic        tstat_we,
  input  logic [31:0] wdata,
  output logic [31:0] tcnt,
  output logic [31:0] tcmp,
  output logic        tstat
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TIMER_DIV - 1);

  logic [PW-1:0] p_q, p_d;
  logic [31:0]   tcnt_q, tcnt_d;
  logic [31:0]   tcmp_q, tcmp_d;
  logic          tstat_q, tstat_d;
  logic          tick_s, hit_s;

  // Next-state: a TCNT write overrides that cycle's tick; a match beats a clear.
  always_comb begin
    tick_s = (p_q == P_LAST);
    p_d    = tick_s ? '0 : p_q + PW'(1);
    tcnt_d = tcnt_q;
    hit_s  = 1'b0;
    if (tcnt_we) begin
      p_d    = '0;
      tcnt_d = wdata;
    end else if (tick_s) begin
      tcnt_d = tcnt_q + 32'd1;
      hit_s  = (tcnt_d == tcmp_q);
    end else begin
      tcnt_d = tcnt_q;
    end
    tcmp_d = tcmp_we ? wdata : tcmp_q;
    if (hit_s) begin
      tstat_d = 1'b1;
    end else if (tstat_we && wdata[0]) begin
      tstat_d = 1'b0;
    end else begin
      tstat_d = tstat_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      tcnt_q  <= 32'h0000_0000;
      tcmp_q  <= 32'hFFFF_FFFF;
      tstat_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      tstat_q <= tstat_d;
    end
  end

  assign tcnt  = tcnt_q;
  assign tcmp  = tcmp_q;
  assign tstat = tstat_q;

endmodule

// File: rtl/bus_bridge.sv
// bus_bridge: decodes core bus accesses to DRAM or the peripheral page
// (SEG/LED/SW/BTN, plus timer registers when BRIDGE_TIMER_EN is defined).
module bus_bridge
  import bus_bridge_pkg::*;
#(
  parameter int DRAM_AW   = 16,
  parameter int LED_W     = 24,
  parameter int SW_W      = 24,
  parameter int TIMER_DIV = 100
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        cpu_addr,
  input  logic               cpu_wen,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [SW_W-1:0]    sw_in,
  input  logic [4:0]         btn_in,
  output logic [LED_W-1:0]   led_out,
  output logic [31:0]        seg_value,
  output logic               timer_irq
);

  logic              page_s, pwen_s;
  logic [11:0]       off_s;
  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       seg_q, seg_d;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
  logic [4:0]        btn_meta_q, btn_sync_q;
  logic [31:0]       tcnt_s, tcmp_s;
  logic              tstat_s;

  assign page_s     = (cpu_addr[31:12] == PERIPH_PAGE);
  assign off_s      = cpu_addr[11:0];
  assign pwen_s     = cpu_wen & page_s;
  assign dram_addr  = cpu_addr[DRAM_AW+1:2];
  assign dram_wdata = cpu_wdata;
  assign dram_wen   = cpu_wen & ~page_s;

`ifdef BRIDGE_TIMER_EN
  bridge_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
    .clk      (cpu_clk),
    .rst      (cpu_rst),
    .tcnt_we  (pwen_s && (off_s == OFF_TCNT)),
    .tcmp_we  (pwen_s && (off_s == OFF_TCMP)),
    .tstat_we (pwen_s && (off_s == OFF_TSTAT)),
    .wdata    (cpu_wdata),
    .tcnt     (tcnt_s),
    .tcmp     (tcmp_s),
    .tstat    (tstat_s)
  );
`else
  assign tcnt_s  = 32'h0000_0000;
  assign tcmp_s  = 32'h0000_0000;
  assign tstat_s = 1'b0;
`endif

  assign timer_irq = tstat_s;

  // Output register write decode.
  always_comb begin
    led_d = led_q;
    seg_d = seg_q;
    if (pwen_s && (off_s == OFF_LED)) begin
      led_d = cpu_wdata[LED_W-1:0];
    end else if (pwen_s && (off_s == OFF_SEG)) begin
      seg_d = cpu_wdata;
    end else begin
      led_d = led_q;
      seg_d = seg_q;
    end
  end

  // Output registers and the two-stage input synchronizers.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      led_q      <= '0;
      seg_q      <= 32'h0000_0000;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= 5'b00000;
      btn_sync_q <= 5'b00000;
    end else begin
      led_q      <= led_d;
      seg_q      <= seg_d;
      sw_meta_q  <= sw_in;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn_in;
      btn_sync_q <= btn_meta_q;
    end
  end

  // Combinational read mux; timer offsets read 0 when the timer is absent.
  always_comb begin
    cpu_rdata = 32'h0000_0000;
    if (!page_s) begin
      cpu_rdata = dram_rdata;
    end else begin
      case (off_s)
        OFF_SEG:   cpu_rdata = seg_q;
        OFF_LED:   cpu_rdata = 32'(led_q);
        OFF_SW:    cpu_rdata = 32'(sw_sync_q);
        OFF_BTN:   cpu_rdata = 32'(btn_sync_q);
        OFF_TCNT:  cpu_rdata = tcnt_s;
        OFF_TCMP:  cpu_rdata = tcmp_s;
        OFF_TSTAT: cpu_rdata = {31'd0, tstat_s};
        default:   cpu_rdata = 32'h0000_0000;
      endcase
    end
  end

  assign led_out   = led_q;
  assign seg_value = seg_q;

endmodule

// File: tb/tb_bus_bridge.sv
// Self-checking bench for bus_bridge: directed scenarios plus random bus
// traffic compared against a behavioural model of the register map.
module tb_bus_bridge;

  localparam int DIV = 4;
`ifdef BRIDGE_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  localparam logic [31:0] A_SEG   = 32'hFFFFF000;
  localparam logic [31:0] A_TCNT  = 32'hFFFFF020;
  localparam logic [31:0] A_TCMP  = 32'hFFFFF024;
  localparam logic [31:0] A_TSTAT = 32'hFFFFF028;
  localparam logic [31:0] A_LED   = 32'hFFFFF060;
  localparam logic [31:0] A_SW    = 32'hFFFFF070;
  localparam logic [31:0] A_BTN   = 32'hFFFFF078;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dram_wdata, dram_rdata, seg_value;
  logic        cpu_wen, dram_wen, timer_irq;
  logic [15:0] dram_addr;
  logic [23:0] sw_in, led_out;
  logic [4:0]  btn_in;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [23:0] m_led;
  logic [31:0] m_seg, m_tcnt, m_tcmp;
  logic        m_tstat;
  int          m_since;
  logic [23:0] sw_dly[$];
  logic [4:0]  btn_dly[$];

  bus_bridge #(.DRAM_AW(16), .LED_W(24), .SW_W(24), .TIMER_DIV(DIV)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .cpu_addr(cpu_addr), .cpu_wen(cpu_wen),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .dram_addr(dram_addr),
    .dram_wen(dram_wen), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .sw_in(sw_in), .btn_in(btn_in), .led_out(led_out), .seg_value(seg_value),
    .timer_irq(timer_irq)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_led = '0; m_seg = '0; m_tcnt = '0; m_tcmp = 32'hFFFFFFFF; m_tstat = 1'b0; m_since = 0;
    sw_dly = '{24'd0, 24'd0};
    btn_dly = '{5'd0, 5'd0};
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] drd);
    if (a[31:12] != 20'hFFFFF) return drd;
    if (a == A_SEG) return m_seg;
    if (a == A_LED) return {8'd0, m_led};
    if (a == A_SW) return {8'd0, sw_dly[0]};
    if (a == A_BTN) return {27'd0, btn_dly[0]};
    if (TMR && a == A_TCNT) return m_tcnt;
    if (TMR && a == A_TCMP) return m_tcmp;
    if (TMR && a == A_TSTAT) return {31'd0, m_tstat};
    return 32'd0;
  endfunction

  // Model of one clock edge: ticks every DIV cycles since the last TCNT write or reset.
  task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic set;
    set = 1'b0;
    if (TMR) begin
      if (w && a == A_TCNT) begin
        m_tcnt = d; m_since = 0;
      end else begin
        m_since++;
        if (m_since % DIV == 0) begin
          m_tcnt = m_tcnt + 32'd1;
          set = (m_tcnt == m_tcmp);
        end
      end
      if (w && a == A_TCMP) m_tcmp = d;
      if (set) m_tstat = 1'b1;
      else if (w && a == A_TSTAT && d[0]) m_tstat = 1'b0;
    end
    if (w && a == A_LED) m_led = d[23:0];
    if (w && a == A_SEG) m_seg = d;
    void'(sw_dly.pop_front());  sw_dly.push_back(sw_in);
    void'(btn_dly.pop_front()); btn_dly.push_back(btn_in);
  endtask

  // One bus cycle, entered and left at a falling edge.
  task automatic bus_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] drd, output logic [31:0] rd_seen,
                           output logic dwen_seen, output logic [15:0] daddr_seen);
    cpu_wen = w; cpu_addr = a; cpu_wdata = d; dram_rdata = drd;
    #1;
    check_val("rdata", cpu_rdata, model_read(a, drd));
    check_val("dram_wen", {31'd0, dram_wen}, {31'd0, w && (a[31:12] != 20'hFFFFF)});
    check_val("dram_addr", {16'd0, dram_addr}, {16'd0, a[17:2]});
    check_val("dram_wdata", dram_wdata, d);
    rd_seen = cpu_rdata; dwen_seen = dram_wen; daddr_seen = dram_addr;
    @(posedge cpu_clk);
    model_edge(w, a, d);
    @(negedge cpu_clk);
    check_val("led_out", {8'd0, led_out}, {8'd0, m_led});
    check_val("seg_value", seg_value, m_seg);
    check_val("timer_irq", {31'd0, timer_irq}, {31'd0, m_tstat});
    cpu_wen = 1'b0;
  endtask

  logic [31:0] r;
  logic        dw;
  logic [15:0] da;
  int          first;

  initial begin
    cpu_rst = 1'b1; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0; dram_rdata = '0;
    sw_in = '0; btn_in = '0;
    model_reset();
    @(negedge cpu_clk); @(negedge cpu_clk);
    check_val("rst_led", {8'd0, led_out}, 32'd0);
    check_val("rst_seg", seg_value, 32'd0);
    check_val("rst_irq", {31'd0, timer_irq}, 32'd0);
    cpu_rst = 1'b0;

    // DRAM store then load
    bus_cycle(1'b1, 32'h00000104, 32'hDEADBEEF, 32'h0, r, dw, da);
    check_val("tp_dram_wen", {31'd0, dw}, 32'd1);
    check_val("tp_dram_addr", {16'd0, da}, 32'h41);
    bus_cycle(1'b0, 32'h00000104, 32'h0, 32'hDEADBEEF, r, dw, da);
    check_val("tp_dram_load", r, 32'hDEADBEEF);

    // LED store, unmapped load
    bus_cycle(1'b1, A_LED, 32'h00FF00AA, 32'h0, r, dw, da);
    check_val("tp_led_dwen", {31'd0, dw}, 32'd0);
    check_val("tp_led", {8'd0, led_out}, 32'h00FF00AA);
    bus_cycle(1'b0, 32'hFFFFF064, 32'h0, 32'h12345678, r, dw, da);
    check_val("tp_unmapped", r, 32'd0);

    // switch synchronizer latency
    sw_in = 24'h000005;
    bus_cycle(1'b0, A_SW, 32'h0, 32'h0, r, dw, da);
    check_val("tp_sw_c0", r, 32'd0);
    bus_cycle(1'b0, A_SW, 32'h0, 32'h0, r, dw, da);
    check_val("tp_sw_c1", r, 32'd0);
    bus_cycle(1'b0, A_SW, 32'h0, 32'h0, r, dw, da);
    check_val("tp_sw_c2", r, 32'h5);

    if (TMR) begin
      bus_cycle(1'b1, A_TCMP, 32'd3, 32'h0, r, dw, da);
      bus_cycle(1'b1, A_TCNT, 32'd0, 32'h0, r, dw, da);
      first = 0;
      for (int k = 1; k <= 20; k++) begin
        bus_cycle(1'b0, A_TSTAT, 32'h0, 32'h0, r, dw, da);
        if (timer_irq && first == 0) begin
          first = k;
          break;
        end
      end
      check_val("tp_irq_latency", first, 32'd12);
      bus_cycle(1'b1, A_TSTAT, 32'd1, 32'h0, r, dw, da);
      check_val("tp_irq_clear", {31'd0, timer_irq}, 32'd0);
      bus_cycle(1'b1, A_TCNT, 32'd0, 32'h0, r, dw, da);
      for (int k = 1; k <= 11; k++) bus_cycle(1'b0, A_TCNT, 32'h0, 32'h0, r, dw, da);
      bus_cycle(1'b1, A_TSTAT, 32'd1, 32'h0, r, dw, da);
      check_val("tp_set_wins", {31'd0, timer_irq}, 32'd1);
      bus_cycle(1'b1, A_TCNT, 32'hFFFFFFFF, 32'h0, r, dw, da);
      for (int k = 1; k <= DIV; k++) bus_cycle(1'b0, A_SEG, 32'h0, 32'h0, r, dw, da);
      bus_cycle(1'b0, A_TCNT, 32'h0, 32'h0, r, dw, da);
      check_val("tp_tcnt_wrap", r, 32'd0);
    end else begin
      bus_cycle(1'b1, A_TCNT, 32'd5, 32'h0, r, dw, da);
      bus_cycle(1'b0, A_TCNT, 32'h0, 32'h0, r, dw, da);
      check_val("tp_notimer_tcnt", r, 32'd0);
      check_val("tp_notimer_irq", {31'd0, timer_irq}, 32'd0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, d;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0: a = A_SEG;   1: a = A_TCNT; 2: a = A_TCMP; 3: a = A_TSTAT;
        4: a = A_LED;   5: a = A_SW;   6: a = A_BTN;
        7: a = {20'hFFFFF, 12'($urandom_range(0, 4095))};
        default: a = $urandom & 32'hFFFEFFFF;
      endcase
      d = $urandom;
      if (a == A_TCNT) d = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFE : 32'($urandom_range(0, 15));
      if (a == A_TCMP) d = 32'($urandom_range(0, 20));
      if ($urandom_range(0, 2) == 0) sw_in = 24'($urandom);
      if ($urandom_range(0, 2) == 0) btn_in = 5'($urandom);
      bus_cycle(1'($urandom_range(0, 1)), a, d, $urandom, r, dw, da);
    end

    // async reset between edges; write strobe during reset is lost
    bus_cycle(1'b1, A_LED, 32'h123, 32'h0, r, dw, da);
    bus_cycle(1'b1, A_TCNT, 32'd7, 32'h0, r, dw, da);
    #2 cpu_rst = 1'b1;
    cpu_addr = A_TCNT;
    #1;
    check_val("arst_led", {8'd0, led_out}, 32'd0);
    check_val("arst_irq", {31'd0, timer_irq}, 32'd0);
    check_val("arst_tcnt", cpu_rdata, 32'd0);
    cpu_addr = A_TCMP;
    #1;
    check_val("arst_tcmp", cpu_rdata, TMR ? 32'hFFFFFFFF : 32'd0);
    cpu_wen = 1'b1; cpu_addr = A_LED; cpu_wdata = 32'hAAA;
    @(negedge cpu_clk);
    check_val("arst_wr_lost", {8'd0, led_out}, 32'd0);
    cpu_wen = 1'b0; sw_in = '0; btn_in = '0;
    cpu_rst = 1'b0;
    model_reset();
    bus_cycle(1'b0, A_LED, 32'h0, 32'h0, r, dw, da);
    bus_cycle(1'b0, A_TCMP, 32'h0, 32'h0, r, dw, da);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
